// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, mul/div holds and HALT parking.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
    parameter int MULDIV_CYCLES = 4,
    parameter int ADDR_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        ifid_opcode,
    input  logic [3:0]        ifid_funct,
    input  logic [3:0]        IFID_Fop1,
    input  logic [3:0]        IFID_Fop2,
    input  logic              idex_memread,
    input  logic [3:0]        idex_rd,
    input  logic              ex_branch_taken,
    input  logic [ADDR_W-1:0] ex_branch_target,
    output logic              pc_write,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] pc_target,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              ex_hold,
    output logic              halted,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MULDIV = 2'd1,
        ST_HALT   = 2'd2
    } state_t;

    localparam logic [3:0] MDC_LOAD = 4'(MULDIV_CYCLES - 1);

    state_t     r_state;
    logic [3:0] r_mdc;
    logic       r_halted;

    logic w_load_use;
    logic w_halt_dec;
    logic w_muldiv_dec;

    // Register fields are compared regardless of opcode; r0 never creates a hazard.
    assign w_load_use   = idex_memread && (idex_rd != 4'h0) &&
                          ((idex_rd == IFID_Fop1) || (idex_rd == IFID_Fop2));
    assign w_halt_dec   = (ifid_opcode == 4'hF);
    assign w_muldiv_dec = (ifid_opcode == 4'h0) &&
                          ((ifid_funct == 4'h4) || (ifid_funct == 4'h5));

    assign o_dbg_state = r_state;

    always_comb begin
        pc_write    = 1'b0;
        pc_sel      = 1'b0;
        pc_target   = '0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        ex_hold     = 1'b0;
        halted      = 1'b0;
        if (rst) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    if (ex_branch_taken) begin
                        pc_sel      = 1'b1;
                        pc_target   = ex_branch_target;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (w_load_use || w_halt_dec) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                ST_MULDIV: begin
                    ex_hold = 1'b1;
                end
                ST_HALT: begin
                    idex_bubble = 1'b1;
                    halted      = r_halted;
                end
                default: begin
                    idex_bubble = 1'b1;
                end
            endcase
        end
    end

    // A mul/div blocked by a flush or stall does not issue; it retries next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_mdc    <= 4'h0;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (!ex_branch_taken && !w_load_use) begin
                        if (w_halt_dec) begin
                            r_state  <= ST_HALT;
                            r_halted <= 1'b1;
                        end else if (w_muldiv_dec) begin
                            r_state <= ST_MULDIV;
                            r_mdc   <= MDC_LOAD;
                        end
                    end
                end
                ST_MULDIV: begin
                    r_mdc <= r_mdc - 4'd1;
                    if (r_mdc <= 4'd1) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_HALT: begin
                    r_state  <= ST_HALT;
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 16'h0000;
            r_flush_cnt <= 16'h0000;
        end else begin
            if (!pc_write && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (ifid_flush && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = 16'h0000;
    assign flush_cnt = 16'h0000;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 16-bit, 8-bit-address five-stage datapath. It sits beside the IF/ID buffer and drives the PC, IF/ID and ID/EX write controls. It inserts load-use stalls, flushes on taken branches, holds the pipe for multi-cycle multiply/divide, and parks the machine on HALT.

## Interface
- `MULDIV_CYCLES`, 4: total cycles a mul/div occupies EX; legal range 2–15.
- `ADDR_W`, 8: PC/branch target width.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `ifid_opcode`  in  4  opcode field of the instruction in ID.
- `ifid_funct`  in  4  funct field of the instruction in ID.
- `IFID_Fop1`, `IFID_Fop2`  in  4 each  source register fields of the instruction in ID.
- `idex_memread`  in  1  instruction in EX is a load.
- `idex_rd`  in  4  destination register of the instruction in EX.
- `ex_branch_taken`  in  1  branch resolved taken in EX this cycle.
- `ex_branch_target`  in  ADDR_W  target of that branch.
- `pc_write`  out  1  PC register enable.
- `pc_sel`  out  1  1 = load `pc_target`; 0 = PC+1.
- `pc_target`  out  ADDR_W  redirect address.
- `ifid_write`  out  1  IF/ID buffer enable.
- `ifid_flush`  out  1  IF/ID loads a NOP.
- `idex_bubble`  out  1  ID/EX loads a NOP.
- `ex_hold`  out  1  ID/EX and EX/MEM hold their contents.
- `halted`  out  1  machine parked in HALT.
- `stall_cnt`, `flush_cnt`  out  16 each  performance counters (see Configuration).

## Operation
- FSM states: RUN, MULDIV, HALT. Down-counter `mdc`, 4 bits.
- Defaults in RUN: `pc_write`=1, `ifid_write`=1, all other control outputs 0, `pc_target`=0.
- Priority in RUN, highest first:
  1. **Flush.** When `ex_branch_taken`=1: `pc_sel`=1, `pc_target`=`ex_branch_target`, `ifid_flush`=1, `idex_bubble`=1. Any ID-stage hazard, mul/div or HALT decode is ignored that cycle.
  2. **Load-use.** When `idex_memread`=1, `idex_rd`≠0, and `idex_rd` equals `IFID_Fop1` or `IFID_Fop2`: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1.
     - Fields are compared regardless of opcode.
     - The hazard lasts exactly one cycle because the bubble clears it.
  3. **HALT.** When `ifid_opcode`=4'hF: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1; next state HALT.
  4. **Mul/div issue.** When `ifid_opcode`=4'h0 and `ifid_funct` is 4'h4 or 4'h5, the instruction issues normally this cycle. Next state MULDIV, with `mdc` ← `MULDIV_CYCLES`−1.
- MULDIV:
  - Outputs: `pc_write`=0, `ifid_write`=0, `ex_hold`=1; `ex_branch_taken` is ignored.
  - `mdc` decrements each cycle; on the cycle `mdc`=1, next state is RUN.
  - A mul/div sitting in ID on exit is issued normally in RUN and re-enters MULDIV.
- HALT:
  - Outputs: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1, `halted`=1.
  - All inputs are ignored; only `rst` exits.

## Timing
- Flush, load-use and HALT-entry outputs are combinational from inputs in RUN; there is zero-cycle latency to the enables.
- FSM state, `mdc`, `halted` and the counters are registered.
- Mul/div occupies EX for exactly `MULDIV_CYCLES` cycles: the issue cycle plus `MULDIV_CYCLES`−1 hold cycles.
- Outputs while `rst`=1: `pc_write`=0, `ifid_write`=0, `ifid_flush`=1, `idex_bubble`=1, `ex_hold`=0, `pc_sel`=0, `pc_target`=0, `halted`=0.
- On the first edge with `rst`=1: state ← RUN, `mdc` ← 0, counters ← 0.
- Reset asserted mid-MULDIV or in HALT aborts on that edge; the first cycle after deassert is RUN.
- Simultaneous branch and load-use: the flush wins, no stall is counted, and only `flush_cnt` increments.
- Branch into a HALT in ID: the flush wins, and HALT is not entered.

## Configuration
- `PIPE_PERF_CNT_EN` defined:
  - `stall_cnt` increments, saturating at 16'hFFFF, on every cycle with `pc_write`=0 while `rst`=0.
  - `flush_cnt` increments, saturating, on every cycle with `ifid_flush`=1 while `rst`=0.
  - Both counters clear on reset.
- Undefined: both outputs are tied to 16'h0000 and no counter flops are built.

## Test plan
- Reset release, then a NOP stream (opcode 4'h1, Fop 4'h2/4'h3, no load in EX) -> `pc_write`=`ifid_write`=1 every cycle; `halted`=0; counters stay 0.
- `idex_memread`=1, `idex_rd`=4'h5, `IFID_Fop2`=4'h5 -> exactly one cycle of `pc_write`=0, `ifid_write`=0, `idex_bubble`=1.
  - Repeat with `idex_rd`=4'h0 -> no stall.
- `ex_branch_taken`=1, `ex_branch_target`=8'h3C, together with a load-use hazard -> `pc_sel`=1, `pc_target`=8'h3C, `ifid_flush`=1, `idex_bubble`=1, no stall; `flush_cnt`=1.
- Mul/div (opcode 4'h0, funct 4'h5) with `MULDIV_CYCLES`=4 -> issue cycle, then 3 cycles of `ex_hold`=1 and `pc_write`=0, then RUN; `stall_cnt`=3.
- Opcode 4'hF in ID -> `halted`=1 from the next cycle and held for 20 cycles despite branches; `rst` pulse -> RUN, `halted`=0.
- `rst` asserted on the second MULDIV cycle -> next cycle `ex_hold`=0; after release, normal RUN.
